led_div_seq: RTL and testbench

- Controller for the LED blink counter's configuration port: drives its 5-bit divider select (div) and its one-cycle write-enable strobe (wren).
- Autonomously steps through a table of divider values, holding each for a programmable dwell time.
- Arbitrates that port between the internal sequencer and an external host requester (PS register or debug logic), with host priority.
- Sits between the top-level control registers and the LED counter instance.

---
 rtl/led_ctrl_pkg.sv | 30 +++
 rtl/led_div_seq_if.sv | 24 ++
 rtl/led_dwell_tmr.sv | 35 +++
 rtl/led_div_seq.sv | 130 +++++++++++++
 tb/tb_led_div_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED divider controllers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//   DIV_W          width of the LED counter divider select
//   DIV_RESET_DEF  divider value the LED counter starts from
//   state_t        sequencer FSM states
//   tbl_entry()    extracts entry k from a packed 5-bit divider table
package led_ctrl_pkg;

  localparam int DIV_W     = 5;
  localparam int MAX_STEPS = 16;
  localparam int TBL_MAX_W = MAX_STEPS * DIV_W;

  localparam logic [DIV_W-1:0] DIV_RESET_DEF = 5'd24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2,
    ST_HOST  = 2'd3
  } state_t;

  // The table is passed zero-extended to the largest supported size so one
  // function serves every NUM_STEPS.
  function automatic logic [DIV_W-1:0] tbl_entry(input logic [TBL_MAX_W-1:0] tbl,
                                                 input logic [3:0]           k);
    return tbl[k*DIV_W +: DIV_W];
  endfunction

endpackage

// File: rtl/led_div_seq_if.sv
// Host write request channel plus the LED counter configuration port.
// Latency: n/a (wires only).
// Backpressure: host holds host_req_i level until host_ack_o pulses.
//   master: host side (drives request, observes ack and the LED port)
//   slave : controller side (drives ack, div_o and wren_o)
interface led_div_seq_if;

  logic                           host_req_i;
  logic [led_ctrl_pkg::DIV_W-1:0] host_div_i;
  logic                           host_ack_o;
  logic [led_ctrl_pkg::DIV_W-1:0] div_o;
  logic                           wren_o;

  modport master (
    output host_req_i, host_div_i,
    input  host_ack_o, div_o, wren_o
  );

  modport slave (
    input  host_req_i, host_div_i,
    output host_ack_o, div_o, wren_o
  );

endinterface

// File: rtl/led_dwell_tmr.sv
// Dwell timer: free up-counter with a terminal-count flag at max(max,1)-1.
// Latency: done is combinational from the registered count; clr takes effect next cycle.
// Backpressure: none; the owner decides when to clear.
//   clk100, rst_n : clock, async active-low reset
//   clr           : synchronous clear of the count (wins over counting)
//   max           : dwell length in cycles, 0 treated as 1
//   done          : high in the last cycle of the dwell
module led_dwell_tmr #(
  parameter int DWELL_W = 32
) (
  input  logic               clk100,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [DWELL_W-1:0] max,
  output logic               done
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] last_cnt;

  // A zero dwell would otherwise wrap to all-ones; clamp so it acts as 1.
  assign last_cnt = (max == '0) ? '0 : max - DWELL_W'(1);
  assign done     = (cnt_q == last_cnt);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/led_div_seq.sv
// Sequences the LED counter divider through a table, host writes preempt.
// Latency: host ack 1 cycle after request (2 if it lands on a table write); table write every max(dwell,1)+1 cycles.
// Backpressure: host_req_i is held until host_ack_o; at most one ack every 2 cycles.
//   clk100, rst_n : clock, async active-low reset
//   enable_i      : sequencer run enable (level)
//   step_tbl_i    : packed divider table, entry k at [5k+4:5k]
//   dwell_i       : cycles each table entry is held
//   bus           : host request/ack and LED counter div_o/wren_o
//   step_o        : current or last table index; busy_o: not idle
module led_div_seq
  import led_ctrl_pkg::*;
#(
  parameter int               NUM_STEPS = 4,
  parameter int               DWELL_W   = 32,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_RESET_DEF
) (
  input  logic                         clk100,
  input  logic                         rst_n,
  input  logic                         enable_i,
  input  logic [NUM_STEPS*DIV_W-1:0]   step_tbl_i,
  input  logic [DWELL_W-1:0]           dwell_i,
  led_div_seq_if.slave                 bus,
  output logic [$clog2(NUM_STEPS)-1:0] step_o,
  output logic                         busy_o
);

  localparam int                STEP_W    = $clog2(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t                 state_q;
  logic [STEP_W-1:0]      step_q;
  logic [STEP_W-1:0]      step_nxt;
  logic [DIV_W-1:0]       div_q;
  logic                   wren_q;
  logic                   ack_q;
  logic                   busy_q;
  logic                   tmr_clr;
  logic                   tmr_done;
  logic [TBL_MAX_W-1:0]   tbl_ext;

  assign tbl_ext  = TBL_MAX_W'(step_tbl_i);
  assign step_nxt = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);

  // The count only runs in DWELL, so every entry into DWELL (from a table
  // write or a host write) starts a full dwell.
  assign tmr_clr = (state_q != ST_DWELL);

  led_dwell_tmr #(
    .DWELL_W (DWELL_W)
  ) u_tmr (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .max    (dwell_i),
    .done   (tmr_done)
  );

  // Outputs are registered on the transition into LOAD/HOST, so wren_o and
  // div_o are visible during the LOAD/HOST cycle itself.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      div_q   <= DIV_RESET;
      wren_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      wren_q <= 1'b0;
      ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.host_req_i) begin
            state_q <= ST_HOST;
            div_q   <= bus.host_div_i;
            wren_q  <= 1'b1;
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else if (enable_i) begin
            state_q <= ST_LOAD;
            step_q  <= '0;
            div_q   <= tbl_entry(tbl_ext, 4'd0);
            wren_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        // A request arriving here waits one cycle so two writes never abut.
        ST_LOAD: begin
          state_q <= ST_DWELL;
        end
        ST_DWELL: begin
          // Host wins even on the terminal cycle; the step is then kept.
          if (bus.host_req_i) begin
            state_q <= ST_HOST;
            div_q   <= bus.host_div_i;
            wren_q  <= 1'b1;
            ack_q   <= 1'b1;
          end else if (!enable_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tmr_done) begin
            state_q <= ST_LOAD;
            step_q  <= step_nxt;
            div_q   <= tbl_entry(tbl_ext, 4'(step_nxt));
            wren_q  <= 1'b1;
          end
        end
        ST_HOST: begin
          if (enable_i) begin
            state_q <= ST_DWELL;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.div_o      = div_q;
  assign bus.wren_o     = wren_q;
  assign bus.host_ack_o = ack_q;
  assign step_o         = step_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_led_div_seq.sv
// Testbench for led_div_seq: directed vector table, corner sequences, random run vs model.
// Latency: n/a.
// Backpressure: host requests are held until acknowledged.
module tb_led_div_seq;

  localparam int NS = 4;

  logic              clk100 = 1'b0;
  logic              rst_n;
  logic              en;
  logic [NS*5-1:0]   tbl_bits;
  logic [31:0]       dwell;
  logic [1:0]        step;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int tbl_arr[NS];

  always #5 clk100 = ~clk100;

  led_div_seq_if bus ();

  led_div_seq #(
    .NUM_STEPS (NS),
    .DWELL_W   (32),
    .DIV_RESET (5'd24)
  ) dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .enable_i   (en),
    .step_tbl_i (tbl_bits),
    .dwell_i    (dwell),
    .bus        (bus),
    .step_o     (step),
    .busy_o     (busy)
  );

  typedef struct {
    logic       en;
    logic       req;
    logic [4:0] hd;
    logic       ew;
    logic [4:0] ed;
    logic       ea;
    logic [1:0] es;
    logic       eb;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ew, input logic [4:0] ed,
                         input logic ea, input logic [1:0] es, input logic eb);
    chk({tag, ".wren"}, 32'(bus.wren_o), 32'(ew));
    chk({tag, ".div"},  32'(bus.div_o),  32'(ed));
    chk({tag, ".ack"},  32'(bus.host_ack_o), 32'(ea));
    chk({tag, ".step"}, 32'(step), 32'(es));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic add(input logic en_v, input logic req_v, input logic [4:0] hd_v,
                     input logic ew, input logic [4:0] ed, input logic ea,
                     input logic [1:0] es, input logic eb);
    vec_t v;
    v.en = en_v; v.req = req_v; v.hd = hd_v;
    v.ew = ew; v.ed = ed; v.ea = ea; v.es = es; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic set_tbl();
    for (int k = 0; k < NS; k++) tbl_bits[k*5 +: 5] = 5'(tbl_arr[k]);
  endtask

  task automatic cyc();
    @(posedge clk100);
    @(negedge clk100);
  endtask

  // Reference model: tracks whether the sequencer is running, how many
  // cycles have passed since the last write, and which table step is live.
  // A table write is due once max(dwell,1) quiet cycles follow any write.
  int         m_eff;
  int         m_since;
  int         m_step;
  bit         m_run;
  bit         m_wr;
  bit         m_ack;
  bit         m_hostw;
  logic [4:0] m_div;

  task automatic model_reset();
    m_run = 0; m_since = 0; m_step = 0; m_wr = 0; m_ack = 0; m_hostw = 0;
    m_div = 5'd24;
  endtask

  task automatic host_wr(input logic [4:0] h);
    m_wr = 1; m_ack = 1; m_div = h; m_run = 1; m_hostw = 1; m_since = 0;
  endtask

  task automatic seq_wr();
    m_wr = 1; m_div = 5'(tbl_arr[m_step]); m_run = 1; m_hostw = 0; m_since = 0;
  endtask

  task automatic model_edge(input bit e, input bit r, input logic [4:0] h);
    bit prev_wr;
    prev_wr = m_wr;
    m_wr  = 0;
    m_ack = 0;
    if (!m_run) begin
      if (r) host_wr(h);
      else if (e) begin m_step = 0; seq_wr(); end
    end else if (prev_wr) begin
      // Requests are not taken in a write cycle; enable only matters after a host write.
      if (m_hostw && !e) m_run = 0;
      else m_since = 1;
    end else if (r) begin
      host_wr(h);
    end else if (!e) begin
      m_run = 0;
    end else if (m_since >= m_eff) begin
      m_step = (m_step + 1) % NS;
      seq_wr();
    end else begin
      m_since++;
    end
  endtask

  int rnd_idx = 0;

  task automatic rnd_cycle(input bit drive);
    @(posedge clk100);
    model_edge(en, bus.host_req_i, bus.host_div_i);
    @(negedge clk100);
    chk_out($sformatf("rnd%0d", rnd_idx), m_wr, m_div, m_ack, 2'(m_step), m_run);
    rnd_idx++;
    if (bus.host_req_i) begin
      if (bus.host_ack_o) begin
        if (!drive || $urandom_range(0, 3) != 0) bus.host_req_i = 1'b0;
        else bus.host_div_i = 5'($urandom_range(0, 31));
      end
    end else if (drive && $urandom_range(0, 5) == 0) begin
      bus.host_req_i = 1'b1;
      bus.host_div_i = 5'($urandom_range(0, 31));
    end
    if (!drive) en = 1'b0;
    else if ($urandom_range(0, 24) == 0) en = ~en;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    bus.host_req_i = 1'b0;
    bus.host_div_i = 5'd0;
    dwell = 32'd3;
    tbl_arr = '{3, 7, 11, 15};
    set_tbl();

    // Reset values, during and after reset with the sequencer disabled.
    @(negedge clk100);
    @(negedge clk100);
    chk_out("in_rst", 1'b0, 5'd24, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk_out($sformatf("idle%0d", i), 1'b0, 5'd24, 1'b0, 2'd0, 1'b0);
    end

    // Sequencing, host preemption, terminal-cycle collision, request in LOAD,
    // back-to-back host requests, disable and restart. dwell=3, tbl={3,7,11,15}.
    //  en req hd   wren div ack step busy
    add(1, 0, 0,    1,  3,  0,  0,  1);
    add(1, 0, 0,    0,  3,  0,  0,  1);
    add(1, 0, 0,    0,  3,  0,  0,  1);
    add(1, 0, 0,    0,  3,  0,  0,  1);
    add(1, 0, 0,    1,  7,  0,  1,  1);
    add(1, 0, 0,    0,  7,  0,  1,  1);
    add(1, 1, 20,   1, 20,  1,  1,  1);
    add(1, 0, 0,    0, 20,  0,  1,  1);
    add(1, 0, 0,    0, 20,  0,  1,  1);
    add(1, 0, 0,    0, 20,  0,  1,  1);
    add(1, 0, 0,    1, 11,  0,  2,  1);
    add(1, 0, 0,    0, 11,  0,  2,  1);
    add(1, 0, 0,    0, 11,  0,  2,  1);
    add(1, 0, 0,    0, 11,  0,  2,  1);
    add(1, 1, 9,    1,  9,  1,  2,  1);
    add(1, 0, 0,    0,  9,  0,  2,  1);
    add(1, 0, 0,    0,  9,  0,  2,  1);
    add(1, 0, 0,    0,  9,  0,  2,  1);
    add(1, 0, 0,    1, 15,  0,  3,  1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 15, 0, 3, 1);
    add(1, 0, 0,    1,  3,  0,  0,  1);
    add(1, 1, 17,   0,  3,  0,  0,  1);
    add(1, 1, 17,   1, 17,  1,  0,  1);
    add(1, 1, 17,   0, 17,  0,  0,  1);
    add(1, 1, 18,   1, 18,  1,  0,  1);
    add(0, 0, 0,    0, 18,  0,  0,  0);
    add(0, 0, 0,    0, 18,  0,  0,  0);
    add(1, 0, 0,    1,  3,  0,  0,  1);
    add(1, 0, 0,    0,  3,  0,  0,  1);
    add(0, 0, 0,    0,  3,  0,  0,  0);
    add(0, 0, 0,    0,  3,  0,  0,  0);
    foreach (vq[i]) begin
      en = vq[i].en;
      bus.host_req_i = vq[i].req;
      bus.host_div_i = vq[i].hd;
      cyc();
      chk_out($sformatf("vec%0d", i), vq[i].ew, vq[i].ed, vq[i].ea, vq[i].es, vq[i].eb);
    end

    // dwell=0 behaves as 1: a table write every second cycle.
    dwell = 32'd0;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk_out($sformatf("dw0_%0d", k), (k % 2) == 0, 5'(tbl_arr[(k/2) % NS]),
              1'b0, 2'((k/2) % NS), 1'b1);
    end
    en = 1'b0;
    cyc();
    cyc();
    dwell = 32'd3;

    // Enable dropped mid-dwell of step 1: idle, step kept, restart at entry 0.
    en = 1'b1;
    for (int k = 0; k < 7; k++) cyc();
    chk_out("drop_pre", 1'b0, 5'd7, 1'b0, 2'd1, 1'b1);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk_out($sformatf("drop%0d", k), 1'b0, 5'd7, 1'b0, 2'd1, 1'b0);
    end
    en = 1'b1;
    cyc();
    chk_out("reen", 1'b1, 5'd3, 1'b0, 2'd0, 1'b1);

    // Reset asserted during a host write; the held request is acked after release.
    cyc();
    cyc();
    bus.host_req_i = 1'b1;
    bus.host_div_i = 5'd21;
    cyc();
    chk_out("arst_host", 1'b1, 5'd21, 1'b1, 2'd0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_out("arst_now", 1'b0, 5'd24, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out($sformatf("arst_hold%0d", k), 1'b0, 5'd24, 1'b0, 2'd0, 1'b0);
    end
    rst_n = 1'b1;
    cyc();
    chk_out("arst_rel", 1'b1, 5'd21, 1'b1, 2'd0, 1'b1);
    bus.host_req_i = 1'b0;
    en = 1'b0;
    cyc();

    // Randomized run against the reference model.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 6; k++) rnd_cycle(1'b0);
      case (b)
        0: dwell = 32'd0;
        1: dwell = 32'd1;
        2: dwell = 32'd2;
        default: dwell = 32'($urandom_range(3, 6));
      endcase
      m_eff = (dwell == 32'd0) ? 1 : int'(dwell);
      for (int k = 0; k < NS; k++) tbl_arr[k] = int'($urandom_range(0, 31));
      set_tbl();
      for (int k = 0; k < 400; k++) rnd_cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
